// File: rtl/alu.sv
// Single-cycle registered ALU: combinational decode of alucont over a/b,
// with result, signed-overflow and add/sub flag captured on every rising clk.

package alu_pkg;
   localparam int DATAWIDTH_DEFAULT = 32;

   // Operation codes on alucont[4:0]; alucont[5] selects SUB when the code is OP_ADDSUB.
   typedef enum logic [4:0] {
      OP_AND    = 5'b00000,
      OP_OR     = 5'b00001,
      OP_ADDSUB = 5'b00010,
      OP_SLT    = 5'b00011,
      OP_XOR    = 5'b00100,
      OP_NOR    = 5'b00101,
      OP_LUI    = 5'b00110
   } op_e;
endpackage

module alu #(
   parameter int DATAWIDTH = alu_pkg::DATAWIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [5:0]           alucont,
   output logic [DATAWIDTH-1:0] result,
   output logic                 overflow,
   output logic                 sum
);

   localparam int MSB = DATAWIDTH - 1;

   logic                 is_sub;
   logic [DATAWIDTH-1:0] addsub;
   logic [DATAWIDTH-1:0] lui_val;
   logic [DATAWIDTH-1:0] nxt_result;
   logic                 nxt_overflow;
   logic                 nxt_sum;
   logic                 op_valid;

   assign is_sub  = alucont[5];
   assign addsub  = is_sub ? (a - b) : (a + b);
   assign lui_val = DATAWIDTH'({b[15:0], 16'b0});

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      nxt_result   = '0;
      nxt_overflow = 1'b0;
      nxt_sum      = 1'b0;
      op_valid     = 1'b1;
      case (alucont[4:0])
         alu_pkg::OP_AND:    nxt_result = a & b;
         alu_pkg::OP_OR:     nxt_result = a | b;
         alu_pkg::OP_ADDSUB: begin
            nxt_result = addsub;
            nxt_sum    = 1'b1;
            // Subtraction flips the sign test on b: overflow needs unlike signs.
            if (is_sub)
               nxt_overflow = (a[MSB] != b[MSB]) && (addsub[MSB] != a[MSB]);
            else
               nxt_overflow = (a[MSB] == b[MSB]) && (addsub[MSB] != a[MSB]);
         end
         alu_pkg::OP_SLT:    nxt_result = DATAWIDTH'($signed(a) < $signed(b));
         alu_pkg::OP_XOR:    nxt_result = a ^ b;
         alu_pkg::OP_NOR:    nxt_result = ~(a | b);
         alu_pkg::OP_LUI:    nxt_result = lui_val;
         default:            op_valid   = 1'b0;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result   <= '0;
         overflow <= 1'b0;
         sum      <= 1'b0;
      end else begin
         result   <= nxt_result;
         overflow <= nxt_overflow;
         sum      <= nxt_sum;
      end
   end

   InvalidALUControl_a: assert property (@(posedge clk) disable iff (reset) op_valid)
      else $warning("InvalidALUControl_a: undecoded alucont %b", alucont);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/timing sequences,
// and randomized operations compared against an arithmetic reference model.

module tb_alu;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [5:0]  alucont;
   logic [31:0] result;
   logic        overflow;
   logic        sum;

   int n_checks = 0;
   int n_fail   = 0;

   localparam longint MAX_S = 64'sd2147483647;
   localparam longint MIN_S = -64'sd2147483648;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  op;
      logic [31:0] r;
      logic        ov;
      logic        s;
   } vec_t;

   vec_t vecs[$];

   alu #(.DATAWIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .a        (a),
      .b        (b),
      .alucont  (alucont),
      .result   (result),
      .overflow (overflow),
      .sum      (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [31:0] r, input logic ov, input logic s);
      check({name, ".result"}, result, r);
      check({name, ".overflow"}, {31'b0, overflow}, {31'b0, ov});
      check({name, ".sum"}, {31'b0, sum}, {31'b0, s});
   endtask

   // Applies inputs away from the edge, lets one rising edge capture them, samples 1 time unit later.
   task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic [5:0] vop);
      @(negedge clk);
      a = va;
      b = vb;
      alucont = vop;
      @(posedge clk);
      #1;
   endtask

   // Reference model built from the operation rules using wide signed arithmetic.
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [5:0] op,
                                 output logic [31:0] r, output logic ov, output logic s);
      longint sa;
      longint sb;
      longint t;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      r  = '0;
      ov = 1'b0;
      s  = 1'b0;
      case (op[4:0])
         5'd0: r = ma & mb;
         5'd1: r = ma | mb;
         5'd2: begin
            t  = op[5] ? (sa - sb) : (sa + sb);
            r  = t[31:0];
            ov = (t > MAX_S) || (t < MIN_S);
            s  = 1'b1;
         end
         5'd3: r = (sa < sb) ? 32'd1 : 32'd0;
         5'd4: r = ma ^ mb;
         5'd5: r = ~(ma | mb);
         5'd6: r = mb[15:0] * 32'h0001_0000;
         default: r = '0;
      endcase
   endfunction

   initial begin
      logic [31:0] er;
      logic        eov;
      logic        es;
      logic [5:0]  rop;
      logic [5:0]  valid_ops[8];

      vecs.push_back('{"add_basic",  32'd5,         32'hFFFF_FFFD, 6'b000010, 32'd2,         1'b0, 1'b1});
      vecs.push_back('{"add_ovf",    32'h7FFF_FFFF, 32'd1,         6'b000010, 32'h8000_0000, 1'b1, 1'b1});
      vecs.push_back('{"add_negovf", 32'h8000_0000, 32'h8000_0000, 6'b000010, 32'h0,         1'b1, 1'b1});
      vecs.push_back('{"sub_ovf",    32'h8000_0000, 32'd1,         6'b100010, 32'h7FFF_FFFF, 1'b1, 1'b1});
      vecs.push_back('{"sub_ovf2",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 6'b100010, 32'h8000_0000, 1'b1, 1'b1});
      vecs.push_back('{"sub_basic",  32'd5,         32'd3,         6'b100010, 32'd2,         1'b0, 1'b1});
      vecs.push_back('{"and",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b000000, 32'h00F0_00F0, 1'b0, 1'b0});
      vecs.push_back('{"or",         32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b000001, 32'hFFF0_FFF0, 1'b0, 1'b0});
      vecs.push_back('{"xor",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b000100, 32'hFF00_FF00, 1'b0, 1'b0});
      vecs.push_back('{"nor",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b000101, 32'h000F_000F, 1'b0, 1'b0});
      vecs.push_back('{"and_b5",     32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b100000, 32'h00F0_00F0, 1'b0, 1'b0});
      vecs.push_back('{"slt_m1_1",   32'hFFFF_FFFF, 32'd1,         6'b000011, 32'd1,         1'b0, 1'b0});
      vecs.push_back('{"slt_1_m1",   32'd1,         32'hFFFF_FFFF, 6'b000011, 32'd0,         1'b0, 1'b0});
      vecs.push_back('{"slt_min_1",  32'h8000_0000, 32'd1,         6'b000011, 32'd1,         1'b0, 1'b0});
      vecs.push_back('{"slt_max_m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 6'b100011, 32'd0,         1'b0, 1'b0});
      vecs.push_back('{"lui",        32'hDEAD_BEEF, 32'hABCD_1234, 6'b000110, 32'h1234_0000, 1'b0, 1'b0});
      vecs.push_back('{"lui_b5",     32'h0,         32'h0000_FFFF, 6'b100110, 32'hFFFF_0000, 1'b0, 1'b0});
      vecs.push_back('{"inv_3f",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'b111111, 32'h0,         1'b0, 1'b0});
      vecs.push_back('{"inv_07",     32'h7FFF_FFFF, 32'd1,         6'b000111, 32'h0,         1'b0, 1'b0});

      valid_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b100010,
                    6'b000011, 6'b000100, 6'b000101, 6'b000110};

      // Reset state, observed with the clock running but reset held.
      reset   = 1'b1;
      a       = 32'h7FFF_FFFF;
      b       = 32'd1;
      alucont = 6'b000010;
      #2;
      check_out("reset_hold", 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_out("reset_edge", 32'h0, 1'b0, 1'b0);

      // First edge after reset release captures the current inputs.
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_out("first_after_reset", 32'h8000_0000, 1'b1, 1'b1);

      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].op);
         check_out(vecs[i].name, vecs[i].r, vecs[i].ov, vecs[i].s);
      end

      // Inputs changed mid-cycle only matter at the next edge.
      apply(32'd10, 32'd20, 6'b000010);
      a = 32'd100;
      b = 32'd200;
      #2;
      check("midcycle_hold.result", result, 32'd30);
      @(posedge clk);
      #1;
      check("midcycle_next.result", result, 32'd300);

      // Asynchronous reset mid-stream, then the discarded op must not come back.
      apply(32'h8000_0000, 32'd1, 6'b100010);
      check_out("pre_async", 32'h7FFF_FFFF, 1'b1, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_out("async_reset", 32'h0, 1'b0, 1'b0);
      a       = 32'h0000_00FF;
      b       = 32'h0000_0F0F;
      alucont = 6'b000000;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_out("post_async", 32'h0000_000F, 1'b0, 1'b0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0)
            rop = 6'($urandom_range(0, 63));
         else
            rop = valid_ops[$urandom_range(0, 7)];
         apply($urandom, $urandom, rop);
         model(a, b, alucont, er, eov, es);
         check_out($sformatf("rand%0d_op%b", i, alucont), er, eov, es);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
